// File: rtl/vl_systest_pkg.sv
// Shared types and helpers for the VL lockstep spec-vs-impl compare harness.
package vl_systest_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Base-4 digit encoding of one 4-state stimulus bit.
  localparam logic [1:0] DIG_ZERO = 2'd0;
  localparam logic [1:0] DIG_ONE  = 2'd1;
  localparam logic [1:0] DIG_X    = 2'd2;
  localparam logic [1:0] DIG_Z    = 2'd3;

  // Upper bound on CHANNELS supported by popcount.
  localparam int unsigned MAX_CHANNELS = 64;

  function automatic logic digit_to_fourval(input logic [1:0] d);
    case (d)
      DIG_ZERO: return 1'b0;
      DIG_ONE:  return 1'b1;
      DIG_X:    return 1'bx;
      default:  return 1'bz;
    endcase
  endfunction

  function automatic logic [7:0] popcount(input logic [MAX_CHANNELS-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < int'(MAX_CHANNELS); i++) n = n + 8'(v[i]);
    return n;
  endfunction

  // LSB position of channel 'chan' in a packed bus of 'width'-bit slices.
  function automatic int unsigned slice_lsb(input int unsigned chan, input int unsigned width);
    return chan * width;
  endfunction

endpackage

// File: rtl/vl_fourval_enum.sv
// Base-4 enumeration counter driving two 4-state stimulus buses.
module vl_fourval_enum
  import vl_systest_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic                last,
  output logic [IN_WIDTH-1:0] stim_in1,
  output logic [IN_WIDTH-1:0] stim_in2
);

  localparam int unsigned CW = 4 * IN_WIDTH;

  logic [CW-1:0] cnt;

  // Vector counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc)   cnt <= cnt + CW'(1);
  end

  assign last = &cnt;

  // Low digits feed stim_in2 (stim_in2[0] fastest), high digits feed stim_in1.
  always_comb begin
    stim_in1 = '0;
    stim_in2 = '0;
    for (int i = 0; i < int'(IN_WIDTH); i++) begin
      stim_in2[i] = digit_to_fourval(cnt[2*i +: 2]);
      stim_in1[i] = digit_to_fourval(cnt[2*(i+int'(IN_WIDTH)) +: 2]);
    end
  end

endmodule

// File: rtl/vl_lockstep_compare.sv
// Clocked spec-vs-impl equivalence harness over all 4-state stimulus vectors.
module vl_lockstep_compare
  import vl_systest_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 4,
  parameter int unsigned OUT_WIDTH = 4,
  parameter int unsigned CHANNELS  = 8,
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned CNT_WIDTH = 16,
  localparam int unsigned CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CHANNELS-1:0]           chan_mask,
  input  logic [CHANNELS*OUT_WIDTH-1:0] spec_out,
  input  logic [CHANNELS*OUT_WIDTH-1:0] impl_out,
  output logic [IN_WIDTH-1:0]           stim_in1,
  output logic [IN_WIDTH-1:0]           stim_in2,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [CHANNELS-1:0]           chan_fail,
  output logic [CNT_WIDTH-1:0]          fail_count,
  output logic                          first_valid,
  output logic [CHAN_W-1:0]             first_chan,
  output logic [IN_WIDTH-1:0]           first_in1,
  output logic [IN_WIDTH-1:0]           first_in2
);

  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned SUM_W = CNT_WIDTH + 8;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e               state, state_n;
  logic [SET_W-1:0]     settle, settle_n;
  logic                 clr, inc, last;
  logic [CHANNELS-1:0]  mismatch, chan_fail_n;
  logic [CHAN_W-1:0]    low_chan, first_chan_n;
  logic [SUM_W-1:0]     sum;
  logic [CNT_WIDTH-1:0] sat_count, fail_count_n;
  logic [IN_WIDTH-1:0]  first_in1_n, first_in2_n;
  logic                 first_valid_n, busy_n, done_n, pass_n;

  vl_fourval_enum #(.IN_WIDTH(IN_WIDTH)) u_enum (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .inc      (inc),
    .last     (last),
    .stim_in1 (stim_in1),
    .stim_in2 (stim_in2)
  );

  // Per-channel literal (case-equality) mismatch, gated by the mask.
  always_comb begin
    mismatch = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      mismatch[c] = chan_mask[c] &
        (spec_out[slice_lsb(c, OUT_WIDTH) +: OUT_WIDTH] !== impl_out[slice_lsb(c, OUT_WIDTH) +: OUT_WIDTH]);
    end
  end

  // Lowest-index mismatching channel.
  always_comb begin
    low_chan = '0;
    for (int c = int'(CHANNELS) - 1; c >= 0; c--) begin
      if (mismatch[c]) low_chan = CHAN_W'(c);
    end
  end

  // Saturating accumulate of this vector's mismatch count.
  always_comb begin
    sum       = SUM_W'(fail_count) + SUM_W'(popcount(MAX_CHANNELS'(mismatch)));
    sat_count = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_WIDTH-1:0];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n       = state;
    settle_n      = settle;
    clr           = 1'b0;
    inc           = 1'b0;
    busy_n        = busy;
    done_n        = done;
    chan_fail_n   = chan_fail;
    fail_count_n  = fail_count;
    first_valid_n = first_valid;
    first_chan_n  = first_chan;
    first_in1_n   = first_in1;
    first_in2_n   = first_in2;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n       = ST_DRIVE;
          settle_n      = '0;
          clr           = 1'b1;
          busy_n        = 1'b1;
          done_n        = 1'b0;
          chan_fail_n   = '0;
          fail_count_n  = '0;
          first_valid_n = 1'b0;
          first_chan_n  = '0;
          first_in1_n   = '0;
          first_in2_n   = '0;
        end
      end
      ST_DRIVE: begin
        if (settle == SET_W'(SETTLE - 1)) begin
          state_n  = ST_CHECK;
          settle_n = '0;
        end else begin
          settle_n = settle + SET_W'(1);
        end
      end
      ST_CHECK: begin
        chan_fail_n  = chan_fail | mismatch;
        fail_count_n = sat_count;
        if (!first_valid && (mismatch != '0)) begin
          first_valid_n = 1'b1;
          first_chan_n  = low_chan;
          first_in1_n   = stim_in1;
          first_in2_n   = stim_in2;
        end
        if (last) begin
          state_n = ST_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          state_n = ST_DRIVE;
          inc     = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    pass_n = done_n && (fail_count_n == '0);
  end

  // State and registered outputs; reset discards any partial run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      settle      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      chan_fail   <= '0;
      fail_count  <= '0;
      first_valid <= 1'b0;
      first_chan  <= '0;
      first_in1   <= '0;
      first_in2   <= '0;
    end else begin
      state       <= state_n;
      settle      <= settle_n;
      busy        <= busy_n;
      done        <= done_n;
      pass        <= pass_n;
      chan_fail   <= chan_fail_n;
      fail_count  <= fail_count_n;
      first_valid <= first_valid_n;
      first_chan  <= first_chan_n;
      first_in1   <= first_in1_n;
      first_in2   <= first_in2_n;
    end
  end

endmodule

// File: tb/tb_vl_lockstep_compare.sv
// Directed bench for vl_lockstep_compare: ordering, faults, masking, saturation, X/Z, reset, restart.
module tb_vl_lockstep_compare;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // DUT A: IN_WIDTH=1, two channels, SETTLE=1 -> 16 vectors, 32 cycles per run.
  logic       start_a;
  logic [1:0] mask_a;
  logic [7:0] spec_a, impl_base_a, impl_a;
  logic       fault_a;
  int         cur_vec;
  logic       a_in1, a_in2, a_busy, a_done, a_pass, a_fv, a_fc, a_fi1, a_fi2;
  logic [1:0] a_cf;
  logic [15:0] a_cnt;

  // ch1 LSB flips on vectors 8..11, i.e. where stim_in1 is the X digit.
  assign impl_a = (fault_a && cur_vec >= 8 && cur_vec <= 11) ? (impl_base_a ^ 8'h10) : impl_base_a;

  vl_lockstep_compare #(.IN_WIDTH(1), .OUT_WIDTH(4), .CHANNELS(2), .SETTLE(1), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .chan_mask(mask_a), .spec_out(spec_a), .impl_out(impl_a),
    .stim_in1(a_in1), .stim_in2(a_in2), .busy(a_busy), .done(a_done), .pass(a_pass),
    .chan_fail(a_cf), .fail_count(a_cnt), .first_valid(a_fv), .first_chan(a_fc),
    .first_in1(a_fi1), .first_in2(a_fi2)
  );

  // DUT B: eight channels all failing every vector, 4-bit saturating count, SETTLE=2.
  logic        start_b;
  logic [31:0] spec_b, impl_b;
  logic        b_in1, b_in2, b_busy, b_done, b_pass, b_fv, b_fi1, b_fi2;
  logic [7:0]  b_cf;
  logic [3:0]  b_cnt;
  logic [2:0]  b_fc;

  assign spec_b = 32'h0000_0000;
  assign impl_b = 32'hFFFF_FFFF;

  vl_lockstep_compare #(.IN_WIDTH(1), .OUT_WIDTH(4), .CHANNELS(8), .SETTLE(2), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .chan_mask(8'hFF), .spec_out(spec_b), .impl_out(impl_b),
    .stim_in1(b_in1), .stim_in2(b_in2), .busy(b_busy), .done(b_done), .pass(b_pass),
    .chan_fail(b_cf), .fail_count(b_cnt), .first_valid(b_fv), .first_chan(b_fc),
    .first_in1(b_fi1), .first_in2(b_fi2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic fourval(input int d);
    case (d)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'bx;
      default: return 1'bz;
    endcase
  endfunction

  task automatic check_a_zero(input string tag);
    check(tag, 64'({a_busy, a_done, a_pass, a_cf, a_cnt, a_fv, a_fc, a_fi1, a_fi2, a_in1, a_in2}), 64'(0));
  endtask

  // One run on DUT A. Loop entry for vector k is the falling edge opening its DRIVE cycle.
  task automatic run_a(input bit chk_order, input int busy_start_at, input int abort_at);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    check("a_busy_after_start", 64'(a_busy), 64'(1));
    check("a_stats_cleared", 64'({a_done, a_cf, a_cnt, a_fv}), 64'(0));
    for (int k = 0; k < 16; k++) begin
      cur_vec = k;
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_a_zero("a_abort_zero");
        return;
      end
      if (k == busy_start_at) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      if (chk_order) begin
        check($sformatf("a_in1_v%0d", k), 64'(a_in1), 64'(fourval(k / 4)));
        check($sformatf("a_in2_v%0d", k), 64'(a_in2), 64'(fourval(k % 4)));
      end
      if (k == 15) check("a_done_not_early", 64'(a_done), 64'(0));
      @(negedge clk);
    end
    check("a_done_on_time", 64'({a_busy, a_done}), 64'(2'b01));
  endtask

  task automatic check_fault_a(input string tag);
    check({tag, "_count"}, 64'(a_cnt), 64'(4));
    check({tag, "_chan_fail"}, 64'(a_cf), 64'(2'b10));
    check({tag, "_first_valid"}, 64'(a_fv), 64'(1));
    check({tag, "_first_chan"}, 64'(a_fc), 64'(1));
    check({tag, "_first_in1"}, 64'(a_fi1), 64'(1'bx));
    check({tag, "_first_in2"}, 64'(a_fi2), 64'(1'b0));
    check({tag, "_pass"}, 64'(a_pass), 64'(0));
  endtask

  logic [3:0] xs, zs;
  logic       lit_diff;

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; cur_vec = 0; fault_a = 1'b0;
    mask_a = 2'b11; spec_a = 8'h5A; impl_base_a = 8'h5A;
    repeat (3) @(negedge clk);
    check_a_zero("a_reset_state");
    check("b_reset_state", 64'({b_busy, b_done, b_pass, b_cf, b_cnt, b_fv, b_fc, b_fi1, b_fi2, b_in1, b_in2}), 64'(0));
    rst = 1'b0;

    // Clean run: full stimulus ordering, timing and pass.
    run_a(1'b1, -1, -1);
    check("clean_pass", 64'({a_pass, a_cnt, a_cf, a_fv}), 64'({1'b1, 16'd0, 2'b00, 1'b0}));

    // Injected ch1 fault with a stray start while busy.
    fault_a = 1'b1;
    run_a(1'b0, 3, -1);
    check_fault_a("fault");

    // Restart straight from DONE reproduces the same result.
    run_a(1'b0, -1, -1);
    check_fault_a("restart");

    // Masking off the faulty channel hides it.
    mask_a = 2'b01;
    run_a(1'b0, -1, -1);
    check("masked", 64'({a_pass, a_cnt, a_cf}), 64'({1'b1, 16'd0, 2'b00}));

    // Reset at vector 5, then a fresh run matches the full-run result.
    mask_a = 2'b11;
    run_a(1'b0, -1, 5);
    repeat (2) @(negedge clk);
    check_a_zero("a_idle_after_abort");
    run_a(1'b0, -1, -1);
    check_fault_a("after_abort");

    // Literal X vs Z on ch0 compares unequal; X vs X compares equal.
    fault_a = 1'b0;
    xs = 4'bxxxx;
    zs = 4'bzzzz;
    lit_diff = (xs !== zs);
    spec_a = {4'h3, xs};
    impl_base_a = {4'h3, zs};
    run_a(1'b0, -1, -1);
    check("xz_count", 64'(a_cnt), lit_diff ? 64'(16) : 64'(0));
    check("xz_chan_fail", 64'(a_cf), 64'({1'b0, lit_diff}));
    check("xz_first", 64'({a_fv, a_fc, a_fi1, a_fi2}), 64'({lit_diff, 3'b000}));
    check("xz_pass", 64'(a_pass), 64'(!lit_diff));
    impl_base_a = {4'h3, xs};
    run_a(1'b0, -1, -1);
    check("xx_match", 64'({a_pass, a_cnt}), 64'({1'b1, 16'd0}));

    // Saturation: 16 vectors x 8 channels clamp a 4-bit count at 15.
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    repeat (16 * 3 - 1) @(negedge clk);
    check("b_done_not_early", 64'(b_done), 64'(0));
    @(negedge clk);
    check("b_done", 64'({b_busy, b_done, b_pass}), 64'(3'b010));
    check("b_sat_count", 64'(b_cnt), 64'(15));
    check("b_chan_fail", 64'(b_cf), 64'(8'hFF));
    check("b_first", 64'({b_fv, b_fc, b_fi1, b_fi2}), 64'({1'b1, 3'd0, 2'b00}));
    repeat (5) @(negedge clk);
    check("b_sat_held", 64'({b_done, b_cnt}), 64'({1'b1, 4'd15}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vl_lockstep_compare.md
Name: vl_lockstep_compare

Overview:
- Generalised, clocked spec-vs-impl equivalence harness for VL systests.
- Enumerates every 4-state (0/1/X/Z) combination of two IN_WIDTH-bit stimulus buses and drives both DUT copies.
- Compares CHANNELS output slices with case-equality (===) after a settle window, and accumulates per-channel failure flags, a saturating failure count and the first failing vector.
- Replaces hand-written nested-loop compare benches; lives in the systest infrastructure beside the generated spec/impl instances.

Parameters:
- IN_WIDTH, 4: bits per stimulus bus (in1, in2); 4*IN_WIDTH must be <= 30.
- OUT_WIDTH, 4: bits per compared output channel.
- CHANNELS, 8: number of compared output channels (>= 1).
- SETTLE, 2: cycles each vector is held before comparison (>= 1).
- CNT_WIDTH, 16: width of fail_count.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a run from IDLE or DONE.
- chan_mask  in  CHANNELS  1 = channel compared; sampled in CHECK.
- spec_out  in  CHANNELS*OUT_WIDTH  spec outputs; channel c = bits [c*OUT_WIDTH +: OUT_WIDTH].
- impl_out  in  CHANNELS*OUT_WIDTH  impl outputs, same packing.
- stim_in1  out  IN_WIDTH  4-state stimulus A.
- stim_in2  out  IN_WIDTH  4-state stimulus B.
- busy  out  1  run in progress.
- done  out  1  run complete; holds until start or rst.
- pass  out  1  done & (fail_count == 0).
- chan_fail  out  CHANNELS  sticky per-channel mismatch flags.
- fail_count  out  CNT_WIDTH  count of failing (vector, channel) pairs, saturating.
- first_valid  out  1  first-failure record is valid.
- first_chan  out  max(1,$clog2(CHANNELS))  lowest-index failing channel of the first failing vector.
- first_in1, first_in2  out  IN_WIDTH each  stimulus of the first failing vector.

Behaviour:
- Reset (synchronous): state IDLE; all outputs 0, including stim_in1/stim_in2 = all 0s; enumeration counter 0.
- rst mid-run aborts at the next edge with the same values; no partial-result retention.
- Enumeration: counter of 2*IN_WIDTH base-4 digits; digit 0->1'b0, 1->1'b1, 2->1'bx, 3->1'bz.
  - Most-significant digit is stim_in1[IN_WIDTH-1]; least-significant is stim_in2[0], which varies fastest.
  - V = 4^(2*IN_WIDTH) vectors, in counter order 0..V-1.
- FSM states:
  - IDLE: start -> DRIVE. Clears stats and counter; busy=1 from the next cycle.
  - DRIVE: stimulus = current vector; settle counter runs 0..SETTLE-1; at SETTLE-1 -> CHECK.
  - CHECK (1 cycle): mismatch[c] = chan_mask[c] & (spec slice !== impl slice). At the edge:
    - chan_fail |= mismatch.
    - fail_count += popcount(mismatch), saturating at 2^CNT_WIDTH-1.
    - If !first_valid and mismatch != 0: capture first_chan, first_in1, first_in2; set first_valid.
    - Then: last vector -> DONE; otherwise increment counter -> DRIVE.
  - DONE: busy=0, done=1; stimulus holds the last vector; start -> DRIVE with stats cleared.
- Per-vector latency is SETTLE+1 cycles. done rises V*(SETTLE+1) edges after the edge that samples start.
- start is ignored while busy.
- Stimulus changes only on the CHECK->DRIVE edge; it is stable throughout DRIVE and CHECK.
- A channel masked off during CHECK never contributes, even if it mismatched.
- X/Z on spec_out/impl_out are compared literally; X vs Z is a mismatch, X vs X is a match.

Decomposition:
- Package vl_systest_pkg:
  - state enum (IDLE, DRIVE, CHECK, DONE).
  - digit-to-4-state constants and function.
  - popcount function.
  - slice-index helper.
- Sub-module vl_fourval_enum: base-4 counter with clear/increment/last outputs, mapping digits to the stim_in1/stim_in2 vectors.

Test Plan:
- Stimulus order: IN_WIDTH=1, SETTLE=1, start. Sample stim each CHECK -> (in1,in2) sequence 00,01,0x,0z,10,...,zz. done rises 32 edges after start; pass=1.
- Single injected fault: CHANNELS=2; impl ch1 differs only when in1==1'bx (IN_WIDTH=1).
  - Required: fail_count=4, chan_fail=2'b10, first_chan=1, first_in1=x, first_in2=0, pass=0.
- Masking and saturation:
  - Same fault with chan_mask=2'b01 -> pass=1, fail_count=0.
  - Every vector fails on all 8 channels with CNT_WIDTH=4 -> fail_count=15, held at 15.
- X/Z literalness: spec drives 4'bxxxx, impl drives 4'bzzzz on ch0 -> every vector fails; first_in1=0, first_in2=0.
- Reset mid-run: rst at vector 5 -> next cycle all outputs 0 and state IDLE. A new start then reproduces the full-run results exactly.
- Start handling:
  - start pulses during busy -> ignored; completion cycle unchanged.
  - start in DONE -> stats cleared the next cycle; second run matches the first.
